// File: rtl/kairo_wb.sv
// kairo write-back stage: merges ALU results with asynchronous load returns,
// tracks one outstanding load per task and drives the register-file write port.
module kairo_wb #(
    parameter int XLEN  = 32,
    parameter int NTASK = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EX_VALID,
    output logic             EX_READY,
    input  logic             EX_TASK,
    input  logic [4:0]       EX_RD,
    input  logic [XLEN-1:0]  EX_RESULT,
    input  logic             EX_IS_LOAD,
    input  logic [2:0]       EX_FUNCT3,
    input  logic [1:0]       EX_ADDR_LO,
    input  logic             DM_RVALID,
    input  logic             DM_RTASK,
    input  logic [XLEN-1:0]  DM_RDATA,
    output logic             WE,
    output logic             WTASKNUM,
    output logic [4:0]       WADDR,
    output logic [XLEN-1:0]  WDATA,
    output logic [NTASK-1:0] LD_PEND,
    output logic [4:0]       PEND_RD0,
    output logic [4:0]       PEND_RD1,
    output logic             ERR
);

    logic [NTASK-1:0] pv;
    logic [4:0]       prd  [NTASK];
    logic [2:0]       pf3  [NTASK];
    logic [1:0]       palo [NTASK];

    logic ret_ok;
    logic ret_wr;
    logic ex_fire;
    logic ld_fire;
    logic alu_wr;

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [1:0] alo,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{alo, 3'b000} +: 8];
        h = w[{alo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // Any valid return claims the write port, even one whose rd is zero.
    assign ret_ok = DM_RVALID && pv[DM_RTASK];
    assign ret_wr = ret_ok && (prd[DM_RTASK] != 5'd0);

    always_comb begin
        EX_READY = 1'b1;
        if (EX_IS_LOAD)
            EX_READY = !pv[EX_TASK] || (ret_ok && (DM_RTASK == EX_TASK));
        else if (EX_RD != 5'd0)
            EX_READY = !ret_ok;
    end

    assign ex_fire = EX_VALID && EX_READY;
    assign ld_fire = ex_fire && EX_IS_LOAD;
    assign alu_wr  = ex_fire && !EX_IS_LOAD && (EX_RD != 5'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            WE       <= 1'b0;
            WTASKNUM <= 1'b0;
            WADDR    <= 5'd0;
            WDATA    <= '0;
            ERR      <= 1'b0;
            pv       <= '0;
            for (int i = 0; i < NTASK; i++) begin
                prd[i]  <= 5'd0;
                pf3[i]  <= 3'd0;
                palo[i] <= 2'd0;
            end
        end else begin
            ERR <= DM_RVALID && !pv[DM_RTASK];
            WE  <= ret_wr || alu_wr;
            if (ret_wr) begin
                WTASKNUM <= DM_RTASK;
                WADDR    <= prd[DM_RTASK];
                WDATA    <= load_ext(pf3[DM_RTASK], palo[DM_RTASK], DM_RDATA);
            end else if (alu_wr) begin
                WTASKNUM <= EX_TASK;
                WADDR    <= EX_RD;
                WDATA    <= EX_RESULT;
            end
            if (ret_ok)
                pv[DM_RTASK] <= 1'b0;
            // Allocation after free so a same-task free/reallocate keeps the entry.
            if (ld_fire) begin
                pv[EX_TASK]   <= 1'b1;
                prd[EX_TASK]  <= EX_RD;
                pf3[EX_TASK]  <= EX_FUNCT3;
                palo[EX_TASK] <= EX_ADDR_LO;
            end
        end
    end

    assign LD_PEND  = pv;
    assign PEND_RD0 = pv[0] ? prd[0] : 5'd0;
    assign PEND_RD1 = pv[1] ? prd[1] : 5'd0;

endmodule

// File: tb/tb_kairo_wb.sv
// Scoreboard bench for kairo_wb: driver pushes per-cycle expectations from a
// behavioural model, an independent monitor pops and compares them.
module tb_kairo_wb;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EX_VALID = 1'b0;
    logic        EX_READY;
    logic        EX_TASK = 1'b0;
    logic [4:0]  EX_RD = '0;
    logic [31:0] EX_RESULT = '0;
    logic        EX_IS_LOAD = 1'b0;
    logic [2:0]  EX_FUNCT3 = '0;
    logic [1:0]  EX_ADDR_LO = '0;
    logic        DM_RVALID = 1'b0;
    logic        DM_RTASK = 1'b0;
    logic [31:0] DM_RDATA = '0;
    logic        WE;
    logic        WTASKNUM;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic [1:0]  LD_PEND;
    logic [4:0]  PEND_RD0;
    logic [4:0]  PEND_RD1;
    logic        ERR;

    kairo_wb #(.XLEN(32), .NTASK(2)) dut (
        .CLK(CLK), .RST(RST),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_TASK(EX_TASK),
        .EX_RD(EX_RD), .EX_RESULT(EX_RESULT), .EX_IS_LOAD(EX_IS_LOAD),
        .EX_FUNCT3(EX_FUNCT3), .EX_ADDR_LO(EX_ADDR_LO),
        .DM_RVALID(DM_RVALID), .DM_RTASK(DM_RTASK), .DM_RDATA(DM_RDATA),
        .WE(WE), .WTASKNUM(WTASKNUM), .WADDR(WADDR), .WDATA(WDATA),
        .LD_PEND(LD_PEND), .PEND_RD0(PEND_RD0), .PEND_RD1(PEND_RD1), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        we;
        bit        err;
        bit        tsk;
        bit [4:0]  rd;
        bit [31:0] data;
        bit [1:0]  pend;
        bit [4:0]  prd0;
        bit [4:0]  prd1;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: one outstanding load per task.
    bit        m_v   [2];
    bit [4:0]  m_rd  [2];
    bit [2:0]  m_f3  [2];
    bit [1:0]  m_alo [2];
    bit        last_t;
    bit [4:0]  last_rd;
    bit [31:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit [31:0] ref_load(bit [2:0] f3, bit [1:0] alo, bit [31:0] w);
        bit [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (int'(alo) * 8)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> ((int'(alo) / 2) * 16)) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic step(input bit rst, input bit v, input bit tsk, input bit [4:0] rd,
                        input bit [31:0] res, input bit ld, input bit [2:0] f3,
                        input bit [1:0] alo, input bit rv, input bit rt, input bit [31:0] rdata);
        exp_t e;
        bit   ret_ok, rdy;
        @(negedge CLK);
        #2;
        RST = rst; EX_VALID = v; EX_TASK = tsk; EX_RD = rd; EX_RESULT = res;
        EX_IS_LOAD = ld; EX_FUNCT3 = f3; EX_ADDR_LO = alo;
        DM_RVALID = rv; DM_RTASK = rt; DM_RDATA = rdata;
        #1;
        ret_ok = rv && m_v[rt];
        if (ld) rdy = !m_v[tsk] || (ret_ok && rt == tsk);
        else    rdy = (rd == 0) || !ret_ok;
        chk("ex_ready", {31'd0, EX_READY}, {31'd0, rdy});
        e.we = 0;
        e.err = 0;
        if (rst) begin
            m_v[0] = 0; m_v[1] = 0;
            last_t = 0; last_rd = 0; last_data = 0;
        end else begin
            e.err = rv && !m_v[rt];
            if (ret_ok) begin
                m_v[rt] = 0;
                if (m_rd[rt] != 0) begin
                    e.we = 1; last_t = rt; last_rd = m_rd[rt];
                    last_data = ref_load(m_f3[rt], m_alo[rt], rdata);
                end
            end else if (v && rdy && !ld && rd != 0) begin
                e.we = 1; last_t = tsk; last_rd = rd; last_data = res;
            end
            if (v && rdy && ld) begin
                m_v[tsk] = 1; m_rd[tsk] = rd; m_f3[tsk] = f3; m_alo[tsk] = alo;
            end
        end
        e.tsk  = last_t;
        e.rd   = last_rd;
        e.data = last_data;
        e.pend = {m_v[1], m_v[0]};
        e.prd0 = m_v[0] ? m_rd[0] : 5'd0;
        e.prd1 = m_v[1] ? m_rd[1] : 5'd0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we",       {31'd0, WE},       {31'd0, e.we});
                chk("err",      {31'd0, ERR},      {31'd0, e.err});
                chk("wtasknum", {31'd0, WTASKNUM}, {31'd0, e.tsk});
                chk("waddr",    {27'd0, WADDR},    {27'd0, e.rd});
                chk("wdata",    WDATA,             e.data);
                chk("ld_pend",  {30'd0, LD_PEND},  {30'd0, e.pend});
                chk("pend_rd0", {27'd0, PEND_RD0}, {27'd0, e.prd0});
                chk("pend_rd1", {27'd0, PEND_RD1}, {27'd0, e.prd1});
            end
        end
    end

    initial begin : driver
        bit drained;
        m_v[0] = 0; m_v[1] = 0;
        m_rd[0] = 0; m_rd[1] = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU writes, rd=0 suppressed
        step(0, 1, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        // LB / LBU
        step(0, 1, 0, 3, 0, 1, 3'b000, 2, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0080_FF11);
        step(0, 1, 0, 3, 0, 1, 3'b100, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0080_FF11);
        // LH / LHU variants
        step(0, 1, 1, 9, 0, 1, 3'b001, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8001_7FFF);
        step(0, 1, 1, 9, 0, 1, 3'b101, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8001_7FFF);
        step(0, 1, 1, 9, 0, 1, 3'b001, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8001_7FFF);
        // Port conflict: task 1 return beats task 0 ALU rd=7
        step(0, 1, 1, 4, 0, 1, 3'b010, 0, 0, 0, 0);
        step(0, 1, 0, 7, 32'hA5A5_0007, 0, 0, 0, 1, 1, 32'hCAFE_F00D);
        step(0, 1, 0, 7, 32'hA5A5_0007, 0, 0, 0, 0, 0, 0);
        // Second load same task: stall, then free+reallocate
        step(0, 1, 0, 10, 0, 1, 3'b010, 0, 0, 0, 0);
        step(0, 1, 0, 11, 0, 1, 3'b000, 1, 0, 0, 0);
        step(0, 1, 0, 11, 0, 1, 3'b000, 1, 1, 0, 32'h1111_2222);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_8000);
        // Stray response, then reset discarding a pending load
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5555_5555);
        step(0, 1, 1, 12, 0, 1, 3'b010, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h7777_7777);
        idle();
        // Randomized traffic, including simultaneous return/accept/stall
        for (int i = 0; i < 3000; i++) begin
            bit [4:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0,
                 1'($urandom_range(0, 1)),
                 rd,
                 $urandom,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom);
        end
        idle();
        drained = 0;
        for (int k = 0; k < 20 && !drained; k++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0) drained = 1;
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 queued expectations", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
